apb_master_bridge: RTL

Upstream neighbour of the APB bus interface. Accepts single read/write commands over a valid/ready request channel and runs the APB SETUP/ACCESS protocol. It drives addr, sels, penable, write, wdata, strb and prot. It samples master_ready, rdata and master_error_in, and returns one response per command on a valid/ready response channel. It also decodes the address to a one-hot select and guards against hung slaves with a timeout.

---
 rtl/apb_pkg.sv | 35 +++
 rtl/apb_master_bridge_if.sv | 56 +++++
 rtl/apb_addr_decode.sv | 49 ++++
 rtl/definition.sv | 10 +
 rtl/apb_master_bridge.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, the command
// record and the pprot attribute bits. No ports.
`include "definition.sv"

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_AW = `APB_ADDR_WIDTH;
    localparam int APB_DW = `APB_DATA_WIDTH;

    // pprot bit meanings
    localparam logic [2:0] APB_PROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] APB_PROT_NONSECURE   = 3'b010;
    localparam logic [2:0] APB_PROT_INSTRUCTION = 3'b100;

    typedef struct packed {
        logic                  write;
        logic [APB_AW-1:0]     addr;
        logic [APB_DW-1:0]     wdata;
        logic [APB_DW/8-1:0]   strb;
        logic [2:0]            prot;
    } apb_cmd_t;

    // Width of the slave index field; a single slave still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Signal bundle between the bridge and its environment.
//   command channel : cmd_valid/cmd_ready + cmd_write/addr/wdata/strb/prot
//   response channel: rsp_valid/rsp_ready + rsp_rdata/error/timeout
//   APB side        : addr, sels, penable, write, wdata, strb, prot (out)
//                     master_ready, rdata, master_error_in (in)
// modport master is the bridge, modport slave is everything around it.
`include "definition.sv"

interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH    = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH    = `APB_DATA_WIDTH,
    parameter int SLAVE_DEVICES = `APB_SLAVE_DEVICES
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;
    logic [2:0]                cmd_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_error;
    logic                      rsp_timeout;

    logic [ADDR_WIDTH-1:0]     addr;
    logic [SLAVE_DEVICES-1:0]  sels;
    logic                      penable;
    logic                      write;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   strb;
    logic [2:0]                prot;
    logic                      master_ready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      master_error_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  rsp_ready,
        output addr, sels, penable, write, wdata, strb, prot,
        input  master_ready, rdata, master_error_in
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output rsp_ready,
        input  addr, sels, penable, write, wdata, strb, prot,
        output master_ready, rdata, master_error_in
    );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decoder.
//   addr_i       : byte address
//   sel_o        : one-hot slave select (all zero on decode error)
//   decode_err_o : index beyond the last slave, or any address bit above
//                  the index field set
`include "definition.sv"

module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH      = `APB_ADDR_WIDTH,
    parameter int SLAVE_DEVICES   = `APB_SLAVE_DEVICES,
    parameter int SLAVE_ADDR_BITS = 12
) (
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    output logic [SLAVE_DEVICES-1:0] sel_o,
    output logic                     decode_err_o
);
    localparam int IDXW   = idx_width(SLAVE_DEVICES);
    localparam int HI_LSB = SLAVE_ADDR_BITS + IDXW;
    localparam logic [IDXW:0] N_SLV = SLAVE_DEVICES[IDXW:0];

    logic [IDXW-1:0] idx;
    logic            idx_oob;
    logic            upper_set;
    logic            unused_lo;

    assign idx     = addr_i[SLAVE_ADDR_BITS +: IDXW];
    assign idx_oob = ({1'b0, idx} >= N_SLV);
    // Offset bits inside a slave window play no part in the decode.
    assign unused_lo = ^addr_i[SLAVE_ADDR_BITS-1:0];

    generate
        if (HI_LSB < ADDR_WIDTH) begin : g_upper
            assign upper_set = |addr_i[ADDR_WIDTH-1:HI_LSB];
        end else begin : g_no_upper
            assign upper_set = 1'b0;
        end
    endgenerate

    assign decode_err_o = idx_oob | upper_set;

    genvar gi;
    generate
        for (gi = 0; gi < SLAVE_DEVICES; gi++) begin : g_sel
            assign sel_o[gi] = !decode_err_o && (idx == IDXW'(gi));
        end
    endgenerate
endmodule

// File: rtl/definition.sv
// Default bus widths shared by the bridge, its interface and the decoder.
// APB_ADDR_WIDTH    : paddr width in bits
// APB_DATA_WIDTH    : pwdata/prdata width in bits (multiple of 8)
// APB_SLAVE_DEVICES : number of slaves, i.e. width of the one-hot select
`ifndef APB_DEFINITION_SV
`define APB_DEFINITION_SV
`define APB_ADDR_WIDTH    32
`define APB_DATA_WIDTH    32
`define APB_SLAVE_DEVICES 4
`endif

// File: rtl/apb_master_bridge.sv
// APB master bridge: takes one read/write command at a time, runs the APB
// SETUP/ACCESS phases and returns a single response per command.
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : apb_master_bridge_if.master (command, response, APB signals)
// Every output comes straight from a register. A slave that never raises
// master_ready is abandoned after TIMEOUT_CYCLES ACCESS cycles (0 = wait forever).
`include "definition.sv"

module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH      = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH      = `APB_DATA_WIDTH,
    parameter int SLAVE_DEVICES   = `APB_SLAVE_DEVICES,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    apb_master_bridge_if.master bus
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_LAST_V = TMO_W'(TMO_LAST);
    localparam bit   TMO_EN = (TIMEOUT_CYCLES > 0);

    apb_state_e               state_q, state_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [SLAVE_DEVICES-1:0] sels_q, sels_d;
    logic                     penable_q, penable_d;
    logic                     write_q, write_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]        strb_q, strb_d;
    logic [2:0]               prot_q, prot_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;

    logic [SLAVE_DEVICES-1:0] dec_sel;
    logic                     dec_err;

    apb_addr_decode #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .SLAVE_DEVICES   (SLAVE_DEVICES),
        .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS)
    ) u_decode (
        .addr_i       (bus.cmd_addr),
        .sel_o        (dec_sel),
        .decode_err_o (dec_err)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            sels_q        <= '0;
            penable_q     <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            prot_q        <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            sels_q        <= sels_d;
            penable_q     <= penable_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            prot_q        <= prot_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        sels_d        = sels_q;
        penable_d     = penable_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        prot_d        = prot_q;
        tmo_cnt_d     = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (dec_err) begin
                        // Unmapped address: answer at once, never touch the bus.
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d = SETUP;
                        sels_d  = dec_sel;
                        addr_d  = bus.cmd_addr;
                        write_d = bus.cmd_write;
                        wdata_d = bus.cmd_wdata;
                        strb_d  = bus.cmd_write ? bus.cmd_strb : '0;
                        prot_d  = bus.cmd_prot;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                tmo_cnt_d = '0;
            end
            ACCESS: begin
                if (bus.master_ready) begin
                    state_d       = RESP;
                    sels_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = bus.master_error_in;
                    rsp_timeout_d = 1'b0;
                    // Read data is only meaningful on a clean read.
                    rsp_rdata_d   = (write_q || bus.master_error_in) ? '0 : bus.rdata;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST_V)) begin
                    state_d       = RESP;
                    sels_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (TMO_EN) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.addr        = addr_q;
    assign bus.sels        = sels_q;
    assign bus.penable     = penable_q;
    assign bus.write       = write_q;
    assign bus.wdata       = wdata_q;
    assign bus.strb        = strb_q;
    assign bus.prot        = prot_q;
endmodule
